// File: rtl/xpu_sched_pkg.sv
// Shared definitions for the transmit queue scheduler: queue count, FSM states
// and the contention-window increment helper.
package xpu_sched_pkg;

    localparam int NUM_QUEUE = 4;
    localparam int QIDX_W    = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_BACKOFF = 2'd1,
        TX           = 2'd2,
        WAIT_ACK     = 2'd3
    } sched_state_e;

    // Saturating exponent step; a cw already at or above the ceiling holds.
    function automatic logic [3:0] cw_inc(input logic [3:0] cw, input logic [3:0] cw_max);
        return (cw >= cw_max) ? cw : cw + 4'd1;
    endfunction

endpackage

// File: rtl/tx_queue_sched_if.sv
// Signal bundle between the MAC queue manager (master) and the scheduler (slave).
interface tx_queue_sched_if #(
    parameter int TO_WIDTH = 10
);
    logic                tsf_pulse_1M;
    logic [3:0]          queue_req;
    logic [3:0]          slice_en;
    logic [3:0]          need_ack;
    logic [3:0]          cw_min_q0;
    logic [3:0]          cw_min_q1;
    logic [3:0]          cw_min_q2;
    logic [3:0]          cw_min_q3;
    logic [3:0]          cw_max;
    logic [3:0]          retry_limit;
    logic [TO_WIDTH-1:0] ack_timeout_top;
    logic                backoff_done;
    logic                tx_done;
    logic                ack_ok;
    logic                tx_start;
    logic [1:0]          tx_queue_idx;
    logic [3:0]          cw_exp;
    logic                retrans_in_progress;
    logic                pkt_done;
    logic                pkt_drop;
    logic                busy;

    modport master (
        output tsf_pulse_1M, queue_req, slice_en, need_ack,
               cw_min_q0, cw_min_q1, cw_min_q2, cw_min_q3, cw_max, retry_limit,
               ack_timeout_top, backoff_done, tx_done, ack_ok,
        input  tx_start, tx_queue_idx, cw_exp, retrans_in_progress,
               pkt_done, pkt_drop, busy
    );

    modport slave (
        input  tsf_pulse_1M, queue_req, slice_en, need_ack,
               cw_min_q0, cw_min_q1, cw_min_q2, cw_min_q3, cw_max, retry_limit,
               ack_timeout_top, backoff_done, tx_done, ack_ok,
        output tx_start, tx_queue_idx, cw_exp, retrans_in_progress,
               pkt_done, pkt_drop, busy
    );

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping 3->0.
module rr_arbiter4
    import xpu_sched_pkg::*;
(
    input  logic [NUM_QUEUE-1:0] req,
    input  logic [QIDX_W-1:0]    ptr,
    output logic [QIDX_W-1:0]    grant_idx,
    output logic                 grant_valid
);

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = NUM_QUEUE - 1; i >= 0; i--) begin
            if (req[ptr + QIDX_W'(i)]) begin
                grant_idx   = ptr + QIDX_W'(i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_queue_sched.sv
// Four-queue transmit scheduler: round-robin grant, backoff wait, transmit,
// ACK wait with timeout, and per-queue contention-window retry handling.
module tx_queue_sched
    import xpu_sched_pkg::*;
#(
    parameter int TO_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                tsf_pulse_1M,
    input  logic [3:0]          queue_req,
    input  logic [3:0]          slice_en,
    input  logic [3:0]          need_ack,
    input  logic [3:0]          cw_min_q0,
    input  logic [3:0]          cw_min_q1,
    input  logic [3:0]          cw_min_q2,
    input  logic [3:0]          cw_min_q3,
    input  logic [3:0]          cw_max,
    input  logic [3:0]          retry_limit,
    input  logic [TO_WIDTH-1:0] ack_timeout_top,
    input  logic                backoff_done,
    input  logic                tx_done,
    input  logic                ack_ok,
    output logic                tx_start,
    output logic [1:0]          tx_queue_idx,
    output logic [3:0]          cw_exp,
    output logic                retrans_in_progress,
    output logic                pkt_done,
    output logic                pkt_drop,
    output logic                busy
);

    sched_state_e              state, state_nxt;
    logic [QIDX_W-1:0]         idx, rr_ptr, grant_idx;
    logic                      grant_valid;
    logic [3:0]                retry_cnt;
    logic [TO_WIDTH-1:0]       timer;
    logic                      ack_lat;
    logic [NUM_QUEUE-1:0][3:0] cw, cw_min;

    logic do_grant, do_start, do_load_timer, do_success, do_fail, do_tick;
    logic exhausted, do_retry, do_drop, do_release;

    assign cw_min = {cw_min_q3, cw_min_q2, cw_min_q1, cw_min_q0};

    rr_arbiter4 u_arb (
        .req        (queue_req & slice_en),
        .ptr        (rr_ptr),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign exhausted  = retry_cnt >= retry_limit;
    assign do_retry   = do_fail & ~exhausted;
    assign do_drop    = do_fail & exhausted;
    assign do_release = do_success | do_drop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        do_grant      = 1'b0;
        do_start      = 1'b0;
        do_load_timer = 1'b0;
        do_success    = 1'b0;
        do_fail       = 1'b0;
        do_tick       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    do_grant  = 1'b1;
                    state_nxt = WAIT_BACKOFF;
                end
            end
            WAIT_BACKOFF: begin
                // A flushed queue abandons the slot without touching retry state.
                if (!queue_req[idx]) begin
                    state_nxt = IDLE;
                end else if (backoff_done && slice_en[idx]) begin
                    do_start  = 1'b1;
                    state_nxt = TX;
                end
            end
            TX: begin
                if (tx_done) begin
                    if (ack_lat) begin
                        do_load_timer = 1'b1;
                        state_nxt     = WAIT_ACK;
                    end else begin
                        do_success = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
            end
            WAIT_ACK: begin
                // ack_ok is checked first so a late ACK beats the expiring timer.
                if (ack_ok) begin
                    do_success = 1'b1;
                    state_nxt  = IDLE;
                end else if (timer == '0) begin
                    do_fail   = 1'b1;
                    state_nxt = exhausted ? IDLE : WAIT_BACKOFF;
                end else if (tsf_pulse_1M) begin
                    do_tick = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx                 <= '0;
            rr_ptr              <= '0;
            retry_cnt           <= '0;
            timer               <= '0;
            ack_lat             <= 1'b0;
            tx_start            <= 1'b0;
            pkt_done            <= 1'b0;
            pkt_drop            <= 1'b0;
            retrans_in_progress <= 1'b0;
        end else begin
            tx_start <= do_start;
            pkt_done <= do_success;
            pkt_drop <= do_drop;
            if (do_grant) idx <= grant_idx;
            if (do_start) ack_lat <= need_ack[idx];
            if (do_load_timer)  timer <= ack_timeout_top;
            else if (do_tick)   timer <= timer - TO_WIDTH'(1);
            if (do_release) begin
                retry_cnt           <= '0;
                retrans_in_progress <= 1'b0;
                rr_ptr              <= idx + QIDX_W'(1);
            end else if (do_retry) begin
                retry_cnt           <= retry_cnt + 4'd1;
                retrans_in_progress <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cw <= cw_min;
        end else begin
            for (int q = 0; q < NUM_QUEUE; q++) begin
                if (idx == QIDX_W'(q)) begin
                    if (do_release)    cw[q] <= cw_min[q];
                    else if (do_retry) cw[q] <= cw_inc(cw[q], cw_max);
                end
            end
        end
    end

    assign tx_queue_idx = idx;
    assign cw_exp       = cw[idx];
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_tx_queue_sched.sv
// Scoreboard bench for tx_queue_sched: expected pulses are queued as stimulus
// is driven and matched by a monitor as tx_start/pkt_done/pkt_drop appear.
module tb_tx_queue_sched;

    localparam int TO_W    = 10;
    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_DROP  = 2;

    typedef struct {
        int kind;
        int idx;
        int cw;
        int retrans;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    tx_queue_sched_if #(.TO_WIDTH(TO_W)) sif ();

    tx_queue_sched #(.TO_WIDTH(TO_W)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .tsf_pulse_1M       (sif.tsf_pulse_1M),
        .queue_req          (sif.queue_req),
        .slice_en           (sif.slice_en),
        .need_ack           (sif.need_ack),
        .cw_min_q0          (sif.cw_min_q0),
        .cw_min_q1          (sif.cw_min_q1),
        .cw_min_q2          (sif.cw_min_q2),
        .cw_min_q3          (sif.cw_min_q3),
        .cw_max             (sif.cw_max),
        .retry_limit        (sif.retry_limit),
        .ack_timeout_top    (sif.ack_timeout_top),
        .backoff_done       (sif.backoff_done),
        .tx_done            (sif.tx_done),
        .ack_ok             (sif.ack_ok),
        .tx_start           (sif.tx_start),
        .tx_queue_idx       (sif.tx_queue_idx),
        .cw_exp             (sif.cw_exp),
        .retrans_in_progress(sif.retrans_in_progress),
        .pkt_done           (sif.pkt_done),
        .pkt_drop           (sif.pkt_drop),
        .busy               (sif.busy)
    );

    int   n_chk   = 0;
    int   n_err   = 0;
    int   n_start = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input int idx, input int cw, input int retrans);
        exp_t e;
        e = '{kind, idx, cw, retrans};
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pulse(input int kind, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            case (kind)
                K_START: seen = sif.tx_start;
                K_DONE:  seen = sif.pkt_done;
                default: seen = sif.pkt_drop;
            endcase
            if (!seen) cyc(1);
        end
        chk({tag, "_seen"}, seen, 1);
    endtask

    task automatic send_start();
        sif.backoff_done = 1'b1;
        wait_pulse(K_START, "start");
        sif.backoff_done = 1'b0;
    endtask

    task automatic tx_finish();
        sif.tx_done = 1'b1;
        cyc(1);
        sif.tx_done = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            sif.tsf_pulse_1M = 1'b1;
            cyc(1);
            sif.tsf_pulse_1M = 1'b0;
            cyc(1);
        end
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    exp_t mon_e;
    int   mon_kind;
    logic prev_start = 1'b0, prev_done = 1'b0, prev_drop = 1'b0;
    always @(negedge clk) begin
        if (rstn === 1'b1 && (sif.tx_start || sif.pkt_done || sif.pkt_drop)) begin
            chk("onehot", 32'(sif.tx_start) + 32'(sif.pkt_done) + 32'(sif.pkt_drop), 1);
            if (sif.tx_start) chk("start_len", prev_start, 0);
            if (sif.pkt_done) chk("done_len", prev_done, 0);
            if (sif.pkt_drop) chk("drop_len", prev_drop, 0);
            mon_kind = sif.tx_start ? K_START : (sif.pkt_done ? K_DONE : K_DROP);
            if (sif.tx_start) n_start++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", mon_kind, 99);
            end else begin
                mon_e = sb.pop_front();
                chk("kind", mon_kind, mon_e.kind);
                chk("idx", sif.tx_queue_idx, mon_e.idx);
                if (mon_kind == K_START) begin
                    chk("cw_at_start", sif.cw_exp, mon_e.cw);
                    chk("retrans_at_start", sif.retrans_in_progress, mon_e.retrans);
                end
            end
        end
        prev_start = sif.tx_start;
        prev_done  = sif.pkt_done;
        prev_drop  = sif.pkt_drop;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s0;
    initial begin
        sif.tsf_pulse_1M    = 1'b0;
        sif.queue_req       = 4'b0000;
        sif.slice_en        = 4'b1111;
        sif.need_ack        = 4'b0000;
        sif.cw_min_q0       = 4'd3;
        sif.cw_min_q1       = 4'd2;
        sif.cw_min_q2       = 4'd7;
        sif.cw_min_q3       = 4'd1;
        sif.cw_max          = 4'd8;
        sif.retry_limit     = 4'd2;
        sif.ack_timeout_top = TO_W'(5);
        sif.backoff_done    = 1'b0;
        sif.tx_done         = 1'b0;
        sif.ack_ok          = 1'b0;
        #2 rstn = 1'b0;
        cyc(3);
        chk("rst_busy", sif.busy, 0);
        chk("rst_tx_start", sif.tx_start, 0);
        chk("rst_pkt_done", sif.pkt_done, 0);
        chk("rst_pkt_drop", sif.pkt_drop, 0);
        chk("rst_retrans", sif.retrans_in_progress, 0);
        chk("rst_idx", sif.tx_queue_idx, 0);
        chk("rst_cw_exp", sif.cw_exp, 3);
        rstn = 1'b1;
        cyc(1);

        // Round robin: q0 and q2 pending, q0 first, then q2.
        sif.queue_req = 4'b0101;
        push(K_START, 0, 3, 0);
        push(K_DONE, 0, 0, 0);
        cyc(2);
        chk("rr_busy", sif.busy, 1);
        chk("rr_first_idx", sif.tx_queue_idx, 0);
        send_start();
        tx_finish();
        wait_pulse(K_DONE, "rr_done0");
        push(K_START, 2, 7, 0);
        push(K_DONE, 2, 0, 0);
        cyc(1);
        chk("rr_second_idx", sif.tx_queue_idx, 2);
        send_start();
        tx_finish();
        wait_pulse(K_DONE, "rr_done2");
        sif.queue_req = 4'b0000;
        cyc(2);
        chk("rr_idle", sif.busy, 0);

        // ACK timeout with retries, ending in a drop (rr_ptr=3 -> q0).
        sif.need_ack  = 4'b1111;
        sif.queue_req = 4'b0001;
        s0 = n_start;
        push(K_START, 0, 3, 0);
        cyc(1);
        chk("to_idx", sif.tx_queue_idx, 0);
        send_start();
        tx_finish();
        ticks(4);
        chk("to_retrans_4ticks", sif.retrans_in_progress, 0);
        chk("to_cw_4ticks", sif.cw_exp, 3);
        ticks(1);
        chk("to_retrans_5ticks", sif.retrans_in_progress, 1);
        chk("to_cw_5ticks", sif.cw_exp, 4);
        chk("to_busy_backoff", sif.busy, 1);
        push(K_START, 0, 4, 1);
        send_start();
        tx_finish();
        ticks(5);
        chk("to_cw_second", sif.cw_exp, 5);
        push(K_START, 0, 5, 1);
        push(K_DROP, 0, 0, 0);
        send_start();
        tx_finish();
        ticks(5);
        wait_pulse(K_DROP, "to_drop");
        sif.queue_req = 4'b0000;
        chk("drop_cw_restored", sif.cw_exp, 3);
        chk("drop_retrans", sif.retrans_in_progress, 0);
        chk("drop_busy", sif.busy, 0);
        chk("drop_start_count", n_start - s0, 3);

        // cw saturation at cw_max on q2 (rr_ptr=1), zero timeout.
        sif.retry_limit     = 4'd3;
        sif.ack_timeout_top = '0;
        sif.queue_req       = 4'b0100;
        push(K_START, 2, 7, 0);
        cyc(1);
        // Stray tx_done/ack_ok during backoff must be ignored.
        sif.tx_done = 1'b1;
        sif.ack_ok  = 1'b1;
        cyc(1);
        sif.tx_done = 1'b0;
        sif.ack_ok  = 1'b0;
        cyc(1);
        chk("stray_busy", sif.busy, 1);
        chk("stray_idx", sif.tx_queue_idx, 2);
        chk("stray_retrans", sif.retrans_in_progress, 0);
        for (int i = 0; i < 3; i++) begin
            send_start();
            tx_finish();
            cyc(1);
            chk("sat_retrans", sif.retrans_in_progress, 1);
            chk("sat_cw", sif.cw_exp, 8);
            push(K_START, 2, 8, 1);
        end
        // ack_ok arrives on the same cycle the zero timer would fail.
        push(K_DONE, 2, 0, 0);
        send_start();
        sif.tx_done = 1'b1;
        cyc(1);
        sif.tx_done = 1'b0;
        sif.ack_ok  = 1'b1;
        cyc(1);
        sif.ack_ok  = 1'b0;
        wait_pulse(K_DONE, "coincident_done");
        sif.queue_req = 4'b0000;
        chk("coincident_cw", sif.cw_exp, 7);
        chk("coincident_retrans", sif.retrans_in_progress, 0);
        cyc(3);
        chk("coincident_idle", sif.busy, 0);

        // Flush in backoff keeps rr_ptr (3): re-grant goes to q3, not q0.
        sif.need_ack  = 4'b0000;
        sif.queue_req = 4'b1001;
        cyc(1);
        chk("flush_grant", sif.tx_queue_idx, 3);
        sif.queue_req = 4'b0001;
        cyc(1);
        chk("flush_idle", sif.busy, 0);
        sif.queue_req = 4'b1001;
        cyc(1);
        chk("flush_rr_kept", sif.tx_queue_idx, 3);

        // Reset while waiting for ACK.
        sif.queue_req       = 4'b1000;
        sif.need_ack        = 4'b1111;
        sif.ack_timeout_top = TO_W'(5);
        push(K_START, 3, 1, 0);
        send_start();
        tx_finish();
        chk("wa_busy", sif.busy, 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_busy", sif.busy, 0);
        chk("async_done", sif.pkt_done, 0);
        chk("async_drop", sif.pkt_drop, 0);
        sif.queue_req = 4'b0000;
        cyc(3);
        chk("rst2_cw_exp", sif.cw_exp, 3);
        rstn = 1'b1;
        cyc(5);
        chk("rst2_idle", sif.busy, 0);

        // retry_limit=0 drops on the first failure (rr_ptr=0 -> q1).
        sif.retry_limit     = 4'd0;
        sif.ack_timeout_top = '0;
        sif.queue_req       = 4'b0010;
        push(K_START, 1, 2, 0);
        push(K_DROP, 1, 0, 0);
        cyc(1);
        send_start();
        tx_finish();
        wait_pulse(K_DROP, "rl0_drop");
        sif.queue_req = 4'b0000;
        chk("rl0_cw", sif.cw_exp, 2);
        chk("rl0_retrans", sif.retrans_in_progress, 0);

        cyc(4);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tx_queue_sched.md
TX_QUEUE_SCHED -- requirements
Module: tx_queue_sched

Interface
REQ-001 SHALL have parameter TO_WIDTH, default 10, ACK-timeout counter width in microseconds.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock.
- rstn  in  1  reset, asynchronous, active-low.
- tsf_pulse_1M  in  1  1 us tick.
- queue_req  in  4  per-queue packet-pending flags.
- slice_en  in  4  per-queue time-slice enables.
- need_ack  in  4  per-queue flag: head packet expects ACK.
- cw_min_q0..cw_min_q3  in  4 each  per-queue initial CW exponent.
- cw_max  in  4  CW exponent ceiling.
- retry_limit  in  4  maximum retransmissions.
- ack_timeout_top  in  TO_WIDTH  ACK wait in us.
- backoff_done  in  1  CSMA/CA backoff complete.
- tx_done  in  1  PHY finished transmit, pulse.
- ack_ok  in  1  valid ACK received, pulse.
- tx_start  out  1  one-cycle transmit command.
- tx_queue_idx  out  2  selected queue.
- cw_exp  out  4  CW exponent fed to CSMA/CA cw_min.
- retrans_in_progress  out  1  current packet is a retransmission.
- pkt_done  out  1  success pulse.
- pkt_drop  out  1  retry-exhausted pulse.
- busy  out  1  state != IDLE.

Function
REQ-003 SHALL implement FSM IDLE, WAIT_BACKOFF, TX, WAIT_ACK.
REQ-004 Eligible set = queue_req & slice_en; IDLE with non-empty set SHALL latch a round-robin winner, searching upward from rr_ptr with wrap 3->0, then go to WAIT_BACKOFF next cycle.
REQ-005 Per-queue cw register SHALL be loaded from cw_min_qN at reset and after every pkt_done or pkt_drop of queue N; cw_exp SHALL show the selected queue's cw.
REQ-006 WAIT_BACKOFF: if backoff_done & slice_en[idx] & queue_req[idx], SHALL pulse tx_start one cycle, latch need_ack[idx], and go to TX.
REQ-007 WAIT_BACKOFF: if queue_req[idx] deasserts (flush), SHALL return to IDLE; rr_ptr, retry count and cw SHALL stay unchanged.
REQ-008 TX: on tx_done with latched need_ack=0, SHALL pulse pkt_done and return to IDLE; with need_ack=1, SHALL load timer with ack_timeout_top and go to WAIT_ACK.
REQ-009 WAIT_ACK: timer SHALL decrement on tsf_pulse_1M. ack_ok SHALL mean success. timer==0 without ack_ok SHALL mean failure.
REQ-010 If ack_ok and timer==0 occur in the same cycle, ack_ok SHALL win.
REQ-011 ack_timeout_top=0 SHALL cause failure on the first WAIT_ACK cycle.
REQ-012 Success SHALL pulse pkt_done, clear retry count and retrans_in_progress, reset cw, set rr_ptr=idx+1 mod 4, and go to IDLE.
REQ-013 Failure with retry_cnt<retry_limit SHALL increment retry_cnt, set cw=min(cw+1,cw_max), set retrans_in_progress, and go to WAIT_BACKOFF on the same idx without re-arbitration.
REQ-014 Failure with retry_cnt>=retry_limit SHALL pulse pkt_drop, then apply the same clears and rr_ptr advance as success.
REQ-015 retry_limit=0 SHALL drop on the first failure.
REQ-016 cw SHALL saturate at cw_max and never wrap. If cw_min_qN>cw_max, cw SHALL hold at cw_min_qN.
REQ-017 tx_done outside TX and ack_ok outside WAIT_ACK SHALL be ignored.
REQ-018 tx_start, pkt_done and pkt_drop SHALL be registered, mutually exclusive, and last exactly one cycle.

Reset
REQ-019 rstn low SHALL asynchronously force: state IDLE, rr_ptr 0, retry_cnt 0, timer 0, all outputs 0 except cw_exp, and each cw register to its cw_min_qN.
REQ-020 Reset mid-TX or mid-WAIT_ACK SHALL abandon the packet without pkt_done or pkt_drop.

Structure
REQ-021 State encodings and NUM_QUEUE=4 SHALL reside in shared package xpu_sched_pkg.
REQ-022 Round-robin selection SHALL be one combinational sub-module rr_arbiter4 (inputs: req, ptr; outputs: grant_idx, grant_valid).

Verification
REQ-023 Queues 0 and 2 requesting, rr_ptr=0, backoff_done pulsed -> tx_start with idx 0; after success, next grant is idx 2.
REQ-024 need_ack=1, ack_timeout_top=5, no ack_ok -> failure after 5 ticks; cw goes 3->4; retrans_in_progress=1; returns to WAIT_BACKOFF.
REQ-025 retry_limit=2, ACK always absent -> exactly 3 tx_start pulses, then pkt_drop; cw restored to cw_min.
REQ-026 cw_min=7, cw_max=8, 3 failures -> cw_exp sequence 7,8,8,8.
REQ-027 ack_ok coincident with timer reaching 0 -> pkt_done, no retry.
REQ-028 rstn low during WAIT_ACK -> busy=0 immediately (asynchronous), with no pkt_done or pkt_drop pulse.
